// File: rtl/tx_lane_compactor.sv
// tx_lane_compactor: packs upstream words onto the usable subset of TX
// lanes, with full-width bypass, sync drain and mask-change drop counting.
module tx_lane_compactor #(
  parameter int LANES = 4,
  parameter int UNITW = 48
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_enable,
  input  logic [LANES-1:0]       in_lanemask,
  input  logic                   in_lanemask_en,
  input  logic [UNITW*LANES-1:0] in_txdata,
  input  logic                   in_txdata_valid,
  input  logic                   in_idle,
  input  logic                   in_sync_req,
  output logic                   out_ready,
  output logic [UNITW*LANES-1:0] out_txdata,
  output logic                   out_txdata_valid,
  output logic                   out_empty,
  output logic                   out_flush_done,
  output logic [LANES-1:0]       active_mask,
  output logic [15:0]            drop_count
);
  localparam int DW = UNITW * LANES;
  localparam int BW = 2 * DW;
  localparam int OW = $clog2(2 * LANES + 1);
  localparam int KW = $clog2(LANES + 1);
  localparam logic [OW-1:0] LN = OW'(LANES);

  logic [LANES-1:0] r_mask;
  logic [KW-1:0]    r_k;
  logic [OW-1:0]    r_occ;
  logic [BW-1:0]    r_buf;
  logic [15:0]      r_drop;
  logic             r_arm;

  logic          w_mchg;
  logic          w_byp;
  logic          w_drain;
  logic          w_sdrain;
  logic          w_enq;
  logic          w_flush;
  logic          w_rdy;
  logic          w_vld;
  logic [OW-1:0] w_k;
  logic [OW-1:0] w_drn;
  logic [OW-1:0] w_rem;
  logic [OW-1:0] w_occ_n;
  logic [BW-1:0] w_buf_n;
  logic [DW-1:0] w_map;
  logic [16:0]   w_dsum;

  function automatic logic [KW-1:0] popc(
    input logic [LANES-1:0] m
  );
    logic [KW-1:0]    c;
    logic [LANES-1:0] t;
    c = '0;
    t = m;
    for (int i = 0; i < LANES; i++) begin
      c = c + KW'(t[0]);
      t = t >> 1;
    end
    return c;
  endfunction

  assign w_k = OW'(r_k);

  assign w_mchg = in_enable
               && in_lanemask_en
               && (in_lanemask != '0)
               && (in_lanemask != r_mask);

  assign w_byp = (&r_mask)
              && (r_occ == '0)
              && !w_mchg;

  assign w_drain = in_enable
                && in_idle
                && !w_mchg
                && !w_byp
                && (r_occ >= w_k);

  assign w_sdrain = in_enable
                 && in_idle
                 && in_sync_req
                 && !w_mchg
                 && !w_byp
                 && (r_occ != '0)
                 && (r_occ < w_k);

  always_comb begin
    w_drn = '0;
    unique case (1'b1)
      w_drain:  w_drn = w_k;
      w_sdrain: w_drn = r_occ;
      default:  w_drn = '0;
    endcase
  end

  assign w_rem = r_occ - w_drn;

  assign w_rdy = in_enable
              && !in_sync_req
              && (w_rem <= LN);

  assign w_enq = w_rdy
              && in_txdata_valid
              && !w_mchg
              && !w_byp;

  assign w_occ_n = w_mchg ? '0
                 : (w_enq ? w_rem + LN : w_rem);

  assign w_flush = in_enable
                && in_sync_req
                && (r_occ == '0)
                && r_arm;

  assign w_vld = w_drain || w_sdrain;

  assign w_dsum = {1'b0, r_drop} + 17'(r_occ);

  // Slots at or above occ stay zero, so shifting pads sync drains for free.
  always_comb begin
    w_buf_n = r_buf >> (32'(w_drn) * UNITW);
    if (w_enq)
      w_buf_n = w_buf_n
              | (BW'(in_txdata) << (32'(w_rem) * UNITW));
    if (w_mchg)
      w_buf_n = '0;
  end

  always_comb begin : map
    logic [LANES-1:0] t;
    logic [KW-1:0]    j;
    t = r_mask;
    j = '0;
    w_map = '0;
    for (int l = 0; l < LANES; l++) begin
      if (t[0]) begin
        w_map = w_map
              | (DW'(UNITW'(r_buf >> (32'(j) * UNITW)))
                 << (l * UNITW));
        j = j + KW'(1);
      end
      t = t >> 1;
    end
  end

  always_comb begin
    out_ready        = 1'b0;
    out_txdata_valid = 1'b0;
    out_txdata       = '0;
    out_flush_done   = 1'b0;
    if (reset_n) begin
      out_flush_done = w_flush;
      if (w_byp) begin
        out_ready        = in_idle;
        out_txdata_valid = in_txdata_valid;
        out_txdata       = in_txdata;
      end else begin
        out_ready        = w_rdy;
        out_txdata_valid = w_vld;
        out_txdata       = w_vld ? w_map : '0;
      end
    end
  end

  assign out_empty   = (r_occ == '0);
  assign active_mask = r_mask;
  assign drop_count  = r_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '1;
      r_k    <= KW'(LANES);
      r_occ  <= '0;
      r_buf  <= '0;
      r_drop <= '0;
      r_arm  <= 1'b1;
    end else if (in_enable) begin
      r_k   <= popc(r_mask);
      r_occ <= w_occ_n;
      r_buf <= w_buf_n;
      if (w_mchg) begin
        r_mask <= in_lanemask;
        r_drop <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
      end
      if (!in_sync_req)
        r_arm <= 1'b1;
      else if (w_flush)
        r_arm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_lane_compactor.sv
// Bench for tx_lane_compactor: queue-based reference model compared
// every cycle, plus literal expectations on directed scenarios.
module tb_tx_lane_compactor;
  localparam int L  = 4;
  localparam int U  = 48;
  localparam int DW = L * U;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [L-1:0]  lm = '0;
  logic          lmen = 1'b0;
  logic [DW-1:0] txd = '0;
  logic          txv = 1'b0;
  logic          idle = 1'b1;
  logic          sync = 1'b0;

  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic          o_vld;
  logic          o_emp;
  logic          o_fl;
  logic [L-1:0]  o_mask;
  logic [15:0]   o_drop;

  int checks = 0;
  int failures = 0;

  logic [U-1:0] mq[$];
  logic [L-1:0] m_mask = '1;
  logic [15:0]  m_drop = '0;
  logic         m_arm = 1'b1;

  always #5 clk = ~clk;

  tx_lane_compactor #(.LANES(L), .UNITW(U)) dut (
    .clk             (clk),
    .reset_n         (rst_n),
    .in_enable       (en),
    .in_lanemask     (lm),
    .in_lanemask_en  (lmen),
    .in_txdata       (txd),
    .in_txdata_valid (txv),
    .in_idle         (idle),
    .in_sync_req     (sync),
    .out_ready       (o_rdy),
    .out_txdata      (o_dat),
    .out_txdata_valid(o_vld),
    .out_empty       (o_emp),
    .out_flush_done  (o_fl),
    .active_mask     (o_mask),
    .drop_count      (o_drop)
  );

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pc(input logic [L-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < L; i++) if (m[i]) c++;
    return c;
  endfunction

  function automatic logic [U-1:0] uv(input int w, input int m);
    return {16'hC0DE, 16'(w), 16'(m)};
  endfunction

  function automatic logic [DW-1:0] word(input int w);
    logic [DW-1:0] r;
    for (int m = 0; m < L; m++) r[m*U +: U] = uv(w, m);
    return r;
  endfunction

  // Reference: buffer is a queue of units, k is the popcount of the mask.
  task automatic eval(output logic rdy, output logic vld,
                      output logic emp, output logic fl,
                      output logic [DW-1:0] dat, output int n,
                      output logic mc, output logic byp);
    int occ, k, j;
    occ = mq.size();
    k = pc(m_mask);
    mc = en && lmen && (lm != '0) && (lm != m_mask);
    byp = (m_mask == '1) && (occ == 0) && !mc;
    n = 0;
    if (!mc && !byp && en && idle) begin
      if (occ >= k) n = k;
      else if (sync && occ > 0) n = occ;
    end
    emp = (occ == 0);
    fl = en && sync && (occ == 0) && m_arm;
    dat = '0;
    if (byp) begin
      rdy = idle;
      vld = txv;
      dat = txd;
    end else begin
      rdy = en && !sync && (occ - n <= L);
      vld = (n > 0);
      j = 0;
      for (int l = 0; l < L; l++) begin
        if (m_mask[l]) begin
          if (j < n) dat[l*U +: U] = mq[j];
          j++;
        end
      end
    end
    if (rst_n !== 1'b1) begin
      rdy = 1'b0;
      vld = 1'b0;
      dat = '0;
      fl  = 1'b0;
      emp = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : mdl
    logic r, v, e, f, mc, by;
    logic [DW-1:0] d;
    int n;
    if (!rst_n) begin
      mq.delete();
      m_mask <= '1;
      m_drop <= '0;
      m_arm  <= 1'b1;
    end else begin
      eval(r, v, e, f, d, n, mc, by);
      if (en) begin
        if (mc) begin
          m_drop <= (int'(m_drop) + mq.size() > 65535) ? 16'hFFFF
                    : m_drop + 16'(mq.size());
          mq.delete();
          m_mask <= lm;
        end else begin
          repeat (n) void'(mq.pop_front());
          if (r && txv && !by)
            for (int m = 0; m < L; m++) mq.push_back(txd[m*U +: U]);
        end
        if (!sync) m_arm <= 1'b1;
        else if (f) m_arm <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic r, v, e, f, mc, by;
    logic [DW-1:0] d;
    int n;
    eval(r, v, e, f, d, n, mc, by);
    chk("ready", DW'(o_rdy), DW'(r));
    chk("valid", DW'(o_vld), DW'(v));
    chk("txdata", o_dat, d);
    chk("empty", DW'(o_emp), DW'(e));
    chk("flush_done", DW'(o_fl), DW'(f));
    chk("active_mask", DW'(o_mask), DW'(m_mask));
    chk("drop_count", DW'(o_drop), DW'(m_drop));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] e;
    logic [U-1:0] got[$];
    int w, drops, bad;
    logic acc;

    // Reset with bypass-shaped inputs present: outputs must stay quiet.
    rst_n = 1'b0;
    txd = word(900);
    txv = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_ready", DW'(o_rdy), '0);
    chk("rst_valid", DW'(o_vld), '0);
    chk("rst_data", o_dat, '0);
    chk("rst_empty", DW'(o_emp), DW'(1));
    chk("rst_flush", DW'(o_fl), '0);
    rst_n = 1'b1;

    // Full mask: combinational bypass.
    for (int i = 0; i < 5; i++) begin
      txd = word(i);
      txv = 1'b1;
      #1;
      chk("byp_data", o_dat, word(i));
      chk("byp_empty", DW'(o_emp), DW'(1));
      tick();
    end

    // Mask 0101: units land on lanes 0 and 2.
    txv = 1'b0;
    lmen = 1'b1;
    lm = 4'b0101;
    tick();
    lmen = 1'b0;
    chk("m0101", DW'(o_mask), DW'(4'b0101));
    txd = word(10);
    txv = 1'b1;
    tick();
    txv = 1'b0;
    #1;
    e = '0;
    e[0 +: U] = uv(10, 0);
    e[2*U +: U] = uv(10, 1);
    chk("k2_first", o_dat, e);
    chk("k2_first_v", DW'(o_vld), DW'(1));
    chk("k2_occ2", DW'(o_emp), '0);
    tick();
    #1;
    e = '0;
    e[0 +: U] = uv(10, 2);
    e[2*U +: U] = uv(10, 3);
    chk("k2_second", o_dat, e);
    tick();
    #1;
    chk("k2_empty", DW'(o_emp), DW'(1));
    chk("k2_idle_v", DW'(o_vld), '0);

    // Mask 0111: 100 back-to-back words, order preserved.
    lmen = 1'b1;
    lm = 4'b0111;
    tick();
    lmen = 1'b0;
    w = 0;
    drops = 0;
    for (int c = 0; c < 1000 && w < 100; c++) begin
      txd = word(100 + w);
      txv = 1'b1;
      #2;
      acc = o_rdy;
      if (!acc) drops++;
      if (o_vld)
        for (int l = 0; l < 3; l++) got.push_back(o_dat[l*U +: U]);
      tick();
      if (acc) w++;
    end
    txv = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (o_vld)
        for (int l = 0; l < 3; l++) got.push_back(o_dat[l*U +: U]);
      tick();
    end
    chk("k3_words", DW'(w), DW'(100));
    chk("k3_ready_dropped", DW'(drops > 0), DW'(1));
    chk("k3_units", DW'(got.size()), DW'(399));
    bad = 0;
    for (int i = 0; i < got.size() && i < 399; i++)
      if (got[i] !== uv(100 + i / 4, i % 4)) bad++;
    chk("k3_order", DW'(bad), '0);

    // One leftover unit: sync drain pads, then flush_done pulses once.
    sync = 1'b1;
    #1;
    e = '0;
    e[0 +: U] = uv(199, 3);
    chk("sync_data", o_dat, e);
    chk("sync_valid", DW'(o_vld), DW'(1));
    chk("sync_ready", DW'(o_rdy), '0);
    tick();
    #1;
    chk("flush_pulse", DW'(o_fl), DW'(1));
    chk("flush_empty", DW'(o_emp), DW'(1));
    tick();
    #1;
    chk("flush_once", DW'(o_fl), '0);
    sync = 1'b0;
    tick();
    sync = 1'b1;
    #1;
    chk("flush_rearm", DW'(o_fl), DW'(1));
    tick();
    sync = 1'b0;

    // Build occupancy 6 then change mask: six units dropped.
    txv = 1'b1;
    idle = 1'b0;
    txd = word(300);
    tick();
    idle = 1'b1;
    txd = word(301);
    tick();
    txd = word(302);
    tick();
    txv = 1'b0;
    lmen = 1'b1;
    lm = 4'b1001;
    #1;
    chk("mchg_no_emit", DW'(o_vld), '0);
    tick();
    #1;
    chk("drop6", DW'(o_drop), DW'(6));
    chk("m1001", DW'(o_mask), DW'(4'b1001));
    chk("mchg_empty", DW'(o_emp), DW'(1));
    lm = 4'b0000;
    tick();
    #1;
    chk("zero_mask_ign", DW'(o_mask), DW'(4'b1001));
    lmen = 1'b0;

    // Disabled: state frozen, no handshake.
    txv = 1'b1;
    idle = 1'b0;
    txd = word(400);
    tick();
    txv = 1'b0;
    en = 1'b0;
    idle = 1'b1;
    #1;
    chk("frz_ready", DW'(o_rdy), '0);
    chk("frz_valid", DW'(o_vld), '0);
    tick();
    tick();
    tick();
    en = 1'b1;
    #1;
    e = '0;
    e[0 +: U] = uv(400, 0);
    e[3*U +: U] = uv(400, 1);
    chk("frz_resume", o_dat, e);
    tick();
    tick();

    // Repeated mask flips with a full buffer saturate drop_count.
    for (int it = 0; it < 8200; it++) begin
      txv = 1'b1;
      idle = 1'b0;
      lmen = 1'b0;
      txd = word(it);
      tick();
      tick();
      txv = 1'b0;
      lmen = 1'b1;
      lm = (it % 2 == 1) ? 4'b0111 : 4'b1011;
      tick();
    end
    lmen = 1'b0;
    #1;
    chk("drop_sat", DW'(o_drop), DW'(16'hFFFF));

    // Reset while units are buffered.
    txv = 1'b1;
    idle = 1'b0;
    txd = word(500);
    tick();
    idle = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", DW'(o_rdy), '0);
    chk("mrst_valid", DW'(o_vld), '0);
    chk("mrst_data", o_dat, '0);
    chk("mrst_empty", DW'(o_emp), DW'(1));
    chk("mrst_flush", DW'(o_fl), '0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mrst_mask", DW'(o_mask), DW'(4'b1111));
    chk("mrst_drop", DW'(o_drop), '0);
    txd = word(600);
    #1;
    chk("mrst_byp", o_dat, word(600));
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
